// File: rtl/fenotipo_pkg.sv
// Shared types and geometry helpers for the phenotype loader.
package fenotipo_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD        = 2'd1,
        WAIT_COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;

    function automatic int chrom_w(input int num_les, input int le_conf_w,
                                   input int num_outs, input int out_conf_w);
        return num_les * le_conf_w + num_outs * out_conf_w;
    endfunction

    function automatic int num_words(input int num_les, input int le_conf_w,
                                     input int num_outs, input int out_conf_w,
                                     input int word_w);
        return (chrom_w(num_les, le_conf_w, num_outs, out_conf_w) + word_w - 1) / word_w;
    endfunction

endpackage

// File: rtl/fenotipo_desserializador.sv
// Word counter and shadow register for an incoming chromosome, plus the
// length checks evaluated against the word currently on the input.
module fenotipo_desserializador #(
    parameter int CHROM_W   = 335,
    parameter int WORD_W    = 8,
    parameter int NUM_WORDS = 42
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               accept,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_last,
    output logic [CHROM_W-1:0] shadow,
    output logic               last_ok,
    output logic               short_err,
    output logic               long_err
);

    localparam int CNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_WORDS - 1);

    logic [CNT_W-1:0]   count_reg;
    logic [CHROM_W-1:0] shadow_reg;
    logic               at_end;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (accept) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // The final word may straddle the end of the chromosome; its excess bits are never stored.
    for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_word
        localparam int LO   = gi * WORD_W;
        localparam int BITS = (CHROM_W - LO < WORD_W) ? (CHROM_W - LO) : WORD_W;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                shadow_reg[LO +: BITS] <= '0;
            end else if (clear) begin
                shadow_reg[LO +: BITS] <= '0;
            end else if (accept && count_reg == CNT_W'(gi)) begin
                shadow_reg[LO +: BITS] <= in_data[BITS-1:0];
            end
        end
    end

    assign at_end    = (count_reg == LAST_IDX);
    assign last_ok   = in_last & at_end;
    assign short_err = in_last & ~at_end;
    assign long_err  = ~in_last & at_end;
    assign shadow    = shadow_reg;

endmodule

// File: rtl/fenotipo_carregavel.sv
// Phenotype loader: streams a chromosome into a shadow copy and commits it
// atomically to the active configuration when the evaluator allows.
module fenotipo_carregavel
    import fenotipo_pkg::*;
#(
    parameter int NUM_LES    = 25,
    parameter int LE_CONF_W  = 13,
    parameter int NUM_OUTS   = 2,
    parameter int OUT_CONF_W = 5,
    parameter int WORD_W     = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [WORD_W-1:0]                    in_data,
    input  logic                                 in_last,
    input  logic                                 commit_allow,
    output logic [NUM_LES-1:0][LE_CONF_W-1:0]    conf_les,
    output logic [NUM_OUTS-1:0][OUT_CONF_W-1:0]  conf_outs,
    output logic                                 conf_valid,
    output logic                                 done,
    output logic [1:0]                           err_code
);

    localparam int CHROM_W   = chrom_w(NUM_LES, LE_CONF_W, NUM_OUTS, OUT_CONF_W);
    localparam int NUM_WORDS = num_words(NUM_LES, LE_CONF_W, NUM_OUTS, OUT_CONF_W, WORD_W);
    localparam int OUT_BASE  = NUM_LES * LE_CONF_W;

    state_t             state_reg;
    logic               in_ready_reg;
    logic               conf_valid_reg;
    logic               done_reg;
    logic [1:0]         err_reg;
    logic [CHROM_W-1:0] active_reg;

    logic               word_accept;
    logic               shadow_clear;
    logic [CHROM_W-1:0] shadow;
    logic               last_ok;
    logic               short_err;
    logic               long_err;

    assign word_accept  = in_valid & in_ready_reg;
    assign shadow_clear = start | (word_accept & (short_err | long_err));

    fenotipo_desserializador #(
        .CHROM_W   (CHROM_W),
        .WORD_W    (WORD_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_desserializador (
        .clk       (clk),
        .rst       (rst),
        .clear     (shadow_clear),
        .accept    (word_accept),
        .in_data   (in_data),
        .in_last   (in_last),
        .shadow    (shadow),
        .last_ok   (last_ok),
        .short_err (short_err),
        .long_err  (long_err)
    );

    // start outranks any word accept or commit in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            in_ready_reg   <= 1'b0;
            conf_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= ERR_NONE;
            active_reg     <= '0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                state_reg    <= LOAD;
                in_ready_reg <= 1'b1;
                err_reg      <= ERR_NONE;
            end else begin
                case (state_reg)
                    LOAD: begin
                        if (word_accept) begin
                            if (last_ok) begin
                                state_reg    <= WAIT_COMMIT;
                                in_ready_reg <= 1'b0;
                            end else if (short_err) begin
                                state_reg    <= IDLE;
                                in_ready_reg <= 1'b0;
                                err_reg      <= ERR_SHORT;
                            end else if (long_err) begin
                                state_reg    <= IDLE;
                                in_ready_reg <= 1'b0;
                                err_reg      <= ERR_LONG;
                            end
                        end
                    end
                    WAIT_COMMIT: begin
                        if (commit_allow) begin
                            active_reg     <= shadow;
                            conf_valid_reg <= 1'b1;
                            done_reg       <= 1'b1;
                            state_reg      <= IDLE;
                        end
                    end
                    default: begin
                        state_reg <= state_reg;
                    end
                endcase
            end
        end
    end

    for (genvar gi = 0; gi < NUM_LES; gi++) begin : g_le
        assign conf_les[gi] = active_reg[gi*LE_CONF_W +: LE_CONF_W];
    end

    for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_out
        assign conf_outs[gi] = active_reg[OUT_BASE + gi*OUT_CONF_W +: OUT_CONF_W];
    end

    assign in_ready   = in_ready_reg;
    assign conf_valid = conf_valid_reg;
    assign done       = done_reg;
    assign err_code   = err_reg;

endmodule

// File: tb/tb_fenotipo_carregavel.sv
// Directed bench for the phenotype loader: stimulus pushes expected commit/error
// events into a queue, a monitor pops and compares them as the DUT reports them.
module tb_fenotipo_carregavel;

    localparam int CW = 335;
    localparam int NW = 42;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  commit_allow;
    logic [24:0][12:0]     conf_les;
    logic [1:0][4:0]       conf_outs;
    logic                  conf_valid;
    logic                  done;
    logic [1:0]            err_code;

    typedef struct {
        bit           is_commit;
        logic [1:0]   err;
        logic         valid;
        logic [CW-1:0] cfg;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    logic [CW-1:0] model_active = '0;
    logic          model_valid = 1'b0;
    logic [1:0]    prev_err = 2'd0;

    fenotipo_carregavel dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .commit_allow (commit_allow),
        .conf_les     (conf_les),
        .conf_outs    (conf_outs),
        .conf_valid   (conf_valid),
        .done         (done),
        .err_code     (err_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] wrd(input int pat, input int k);
        case (pat)
            0:       return 8'(k);
            1:       return 8'(k * 37 + 11);
            2:       return ~8'(k);
            default: return 8'(k) ^ 8'h5A;
        endcase
    endfunction

    function automatic logic [CW-1:0] chrom(input int pat);
        logic [NW*8-1:0] v;
        for (int k = 0; k < NW; k++) v[k*8 +: 8] = wrd(pat, k);
        return v[CW-1:0];
    endfunction

    function automatic logic [CW-1:0] actual_cfg();
        logic [CW-1:0] v;
        for (int i = 0; i < 25; i++) v[i*13 +: 13] = conf_les[i];
        for (int j = 0; j < 2; j++) v[325 + j*5 +: 5] = conf_outs[j];
        return v;
    endfunction

    task automatic chk(input string name, input logic [CW-1:0] got, input logic [CW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push_exp(input bit is_commit, input logic [1:0] err, input logic valid,
                            input logic [CW-1:0] cfg);
        exp_t e;
        e.is_commit = is_commit;
        e.err       = err;
        e.valid     = valid;
        e.cfg       = cfg;
        sb_q.push_back(e);
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sends n words of a pattern; last_idx<0 means no in_last; abort_idx>=0 raises start with that word.
    task automatic send_words(input int pat, input int n, input int last_idx, input bit gaps,
                              input int abort_idx);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("in_ready_w%0d", k), CW'(in_ready), CW'(1'b1));
            in_valid = 1'b1;
            in_data  = wrd(pat, k);
            in_last  = (k == last_idx);
            if (k == abort_idx) begin
                start = 1'b1;
                @(negedge clk);
                start    = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                $display("abort load at word %0d", k);
                return;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        $display("sent pattern %0d words=%0d last=%0d", pat, n, last_idx);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_in_ready"}, CW'(in_ready), '0);
        chk({tag, "_conf_valid"}, CW'(conf_valid), '0);
        chk({tag, "_done"}, CW'(done), '0);
        chk({tag, "_err"}, CW'(err_code), '0);
        chk({tag, "_cfg"}, actual_cfg(), '0);
    endtask

    // Scoreboard monitor: a done pulse or a fresh error code is one DUT transaction.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            prev_err = 2'd0;
        end else begin
            if (done === 1'b1 || (err_code !== 2'd0 && prev_err === 2'd0)) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event done=%0b err=%0d", done, err_code);
                end else begin
                    e = sb_q.pop_front();
                    if (e.is_commit !== done || e.err !== err_code || e.valid !== conf_valid
                        || e.cfg !== actual_cfg()) begin
                        errors++;
                        $display("FAIL scoreboard got done=%0b err=%0d valid=%0b cfg=%h exp done=%0b err=%0d valid=%0b cfg=%h",
                                 done, err_code, conf_valid, actual_cfg(),
                                 e.is_commit, e.err, e.valid, e.cfg);
                    end else begin
                        $display("event ok done=%0b err=%0d valid=%0b", done, err_code, conf_valid);
                    end
                end
            end
            prev_err = err_code;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        commit_allow = 1'b1;

        // 1: asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #1 chk_reset_state("t1");
        @(negedge clk);
        rst = 1'b0;

        // 2: full load of word k = k with immediate commit
        push_exp(1'b1, 2'd0, 1'b1, chrom(0));
        do_start();
        send_words(0, NW, NW - 1, 1'b0, -1);
        chk("t2_done_early", CW'(done), '0);
        chk("t2_in_ready_wait", CW'(in_ready), '0);
        @(negedge clk);
        chk("t2_done", CW'(done), CW'(1'b1));
        chk("t2_conf_valid", CW'(conf_valid), CW'(1'b1));
        @(negedge clk);
        chk("t2_done_pulse", CW'(done), '0);
        chk("t2_le0", CW'(conf_les[0]), CW'(13'h100));
        chk("t2_le24", CW'(conf_les[24]), CW'(13'h0827));
        chk("t2_out0", CW'(conf_outs[0]), CW'(5'h09));
        chk("t2_out1", CW'(conf_outs[1]), CW'(5'h0A));
        model_active = chrom(0);
        model_valid  = 1'b1;

        // 3: in_last on word 10 -> short error
        push_exp(1'b0, 2'd1, model_valid, model_active);
        do_start();
        send_words(1, 11, 10, 1'b0, -1);
        chk("t3_err", CW'(err_code), CW'(2'd1));
        chk("t3_in_ready", CW'(in_ready), '0);
        @(negedge clk);
        chk("t3_err_sticky", CW'(err_code), CW'(2'd1));
        chk("t3_cfg", actual_cfg(), model_active);

        // 4: 42 words without in_last -> long error
        push_exp(1'b0, 2'd2, model_valid, model_active);
        do_start();
        chk("t4_err_cleared", CW'(err_code), '0);
        send_words(1, NW, -1, 1'b0, -1);
        chk("t4_err", CW'(err_code), CW'(2'd2));
        chk("t4_in_ready", CW'(in_ready), '0);
        chk("t4_cfg", actual_cfg(), model_active);

        // 5: commit held off for 20 cycles
        push_exp(1'b1, 2'd0, 1'b1, chrom(2));
        commit_allow = 1'b0;
        do_start();
        send_words(2, NW, NW - 1, 1'b0, -1);
        for (int c = 0; c < 20; c++) begin
            chk($sformatf("t5_hold_ready_c%0d", c), CW'(in_ready), '0);
            chk($sformatf("t5_hold_done_c%0d", c), CW'(done), '0);
            @(negedge clk);
        end
        chk("t5_cfg_held", actual_cfg(), model_active);
        commit_allow = 1'b1;
        @(negedge clk);
        chk("t5_done", CW'(done), CW'(1'b1));
        @(negedge clk);
        chk("t5_done_pulse", CW'(done), '0);
        model_active = chrom(2);

        // 6a: restart mid-load at word 20, then a gapped full load commits
        push_exp(1'b1, 2'd0, 1'b1, chrom(3));
        do_start();
        send_words(1, NW, NW - 1, 1'b1, 20);
        chk("t6_cfg_after_abort", actual_cfg(), model_active);
        send_words(3, NW, NW - 1, 1'b1, -1);
        repeat (3) @(negedge clk);
        model_active = chrom(3);

        // 6b: async reset at word 20, then a clean full load
        do_start();
        send_words(2, 20, -1, 1'b1, -1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_state("t6_rst");
        model_active = '0;
        model_valid  = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        push_exp(1'b1, 2'd0, 1'b1, chrom(1));
        do_start();
        send_words(1, NW, NW - 1, 1'b0, -1);
        repeat (3) @(negedge clk);
        model_active = chrom(1);
        chk("t6_final_cfg", actual_cfg(), model_active);

        chk("sb_pending", CW'(sb_q.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
